matrix_scanner: RTL and testbench
=================================

# matrix_scanner

Scans an active-low ROWS×COLS key matrix by strobing one row at a time and reading the column return lines. It is the input-side counterpart of the multiplexed seven-segment driver: it drives strobes out and reads the return lines back, rather than driving digit patterns out. It debounces whole scan frames and reports a single stable key as a code plus a one-cycle valid pulse. It flags simultaneous multi-key presses as an error. It sits between the board's keypad pins and the value/display logic.

## Interface
- ROWS, 4, number of strobed rows (≥2)
- COLS, 4, number of column return lines (≥1)
- SETTLE, 1000, clk cycles each row is held low before its columns are sampled (≥2)
- DEBOUNCE, 4, consecutive identical frame results required to commit (≥1)
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cols  in  COLS  column returns, active-low, asynchronous to clk
- rows  out  ROWS  row strobes, active-low, exactly one low outside reset
- code  out  $clog2(ROWS*COLS)  committed key index = row*COLS + col
- valid  out  1  one-cycle pulse when a new key is committed
- pressed  out  1  level, a single key is currently committed
- error  out  1  level, a multi-key frame is currently committed

## Operation
- cols passes through a 2-FF synchronizer. All sampling uses the synchronized value.
- Dwell counter runs 0..SETTLE-1 per row. The row index advances 0..ROWS-1 and wraps to 0.
- rows is registered. rows[r] is low while the row index is r.
- Sample point: last dwell cycle (dwell == SETTLE-1). Low bits of the synchronized cols count as hits in the current row.
- Frame accumulation across rows:
  - hit count saturates at 2;
  - first hit code is kept, taking the lowest row first, then the lowest col.
- Frame end is the sample of row ROWS-1. Frame result:
  - NONE if hits == 0;
  - ONE(code) if hits == 1;
  - MULTI if hits ≥ 2.
  - Accumulators then clear for the next frame.
- Debounce compares the frame result (kind and, for ONE, the code) with the previous frame result:
  - equal: stable count increments, saturating at DEBOUNCE;
  - different: stable count resets to 1.
  - A commit happens on the frame where the count first reaches DEBOUNCE. With DEBOUNCE=1, every change of result commits.
- Committed-state FSM:
  - IDLE, commit ONE(k) → PRESSED: code←k, valid pulse.
  - PRESSED, commit ONE(k') with k'≠k → PRESSED: code←k', valid pulse.
  - IDLE or PRESSED, commit MULTI → ERROR: no valid pulse.
  - PRESSED, commit NONE → IDLE. code holds its last value.
  - ERROR exits only on commit NONE → IDLE. ONE commits in ERROR are ignored, and the count stays saturated.
- Derived outputs: pressed = (state==PRESSED), error = (state==ERROR).
- Scanning never stops, in any state.

## Timing
- During rst: rows = all ones, code = 0, valid = 0, pressed = 0, error = 0.
- Reset internals: dwell = 0, row = 0, stable count = 0, previous result = NONE, state IDLE.
- First clk edge after rst deasserts: rows = ~1 (row 0 low).
- Frame length is ROWS*SETTLE cycles.
- Outputs and commit:
  - valid, pressed, error and code update on the cycle after the frame-end sample.
  - valid is high for exactly 1 cycle.
- Worst-case press-to-valid latency is (DEBOUNCE+1)*ROWS*SETTLE + 3 cycles (synchronizer + frame-end register).
- rst asserted mid-frame or mid-debounce: everything returns to reset values at once. No valid pulse is emitted for a partially debounced key.

## Structure
- Package matrix_scanner_pkg holds:
  - frame-result kind enum (RES_NONE, RES_ONE, RES_MULTI);
  - FSM state enum (ST_IDLE, ST_PRESSED, ST_ERROR);
  - helper width function for code.
- Dwell counter is an instance of the existing param_counter with UPPER_BOUND=SETTLE and rst connected. Its wrap enables row advance.
- Synchronizer, frame accumulator, debouncer and FSM are inline.

## Test plan
All scenarios use ROWS=4, COLS=4, SETTLE=4, DEBOUNCE=2, so a frame is 16 cycles.
- Reset mid-operation: assert rst at cycle 5 of a frame → rows=4'b1111, all outputs 0. One cycle after release rows=4'b1110. Row 3 is low from cycles 12-15 of each frame.
- Single key: hold row 2/col 1 (cols[1] low only while rows[2] low) for 5 frames → exactly one valid pulse, code=9, pressed=1, error=0.
- Bounce: toggle the row 2/col 1 key every frame for 4 frames → no valid pulse. Then hold it steady → valid with code=9 within 3 frames + 3 cycles.
- Release and re-press: hold key 9, release for 3 frames, press key 0 → pressed falls to 0, code stays 9, then valid with code=0.
- Multi-key: keys 0 and 15 held together → error=1, pressed=0, no valid. Release 0 only → error stays 1. Release all → error=0 after 2 frames.
- Key roll: key 5 committed, then switch directly to key 6 → second valid with code=6, pressed held at 1 throughout.

Source files
------------

// File: rtl/matrix_scanner_pkg.sv
// Shared types and helpers for the keypad matrix scanner: frame-result kinds,
// committed-state encoding and the code-width helper.
package matrix_scanner_pkg;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_ONE   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/param_counter.sv
// Free-running modulo counter 0..UPPER_BOUND-1 with a wrap strobe on the
// final count; used as the per-row dwell timer.
module param_counter #(
  parameter  int UPPER_BOUND = 4,
  localparam int CW          = (UPPER_BOUND > 1) ? $clog2(UPPER_BOUND) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o
);

  logic [CW-1:0] count_q;
  logic          last;

  assign last    = (count_q == CW'(UPPER_BOUND - 1));
  assign count_o = count_q;
  assign wrap_o  = en_i && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= last ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_scanner.sv
// Active-low key matrix scanner: strobes rows, samples synchronized columns,
// debounces whole frames and commits a single key, or flags multi-key presses.
module matrix_scanner
  import matrix_scanner_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COLS-1:0]                     cols,
  output logic [ROWS-1:0]                     rows,
  output logic [code_width(ROWS, COLS)-1:0]   code,
  output logic                                valid,
  output logic                                pressed,
  output logic                                error
);

  localparam int CW  = code_width(ROWS, COLS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SW  = $clog2(DEBOUNCE + 1);

  function automatic logic [1:0] sat_hits(input logic [2:0] v);
    return (v > 3'd2) ? 2'd2 : v[1:0];
  endfunction

  function automatic logic [SW-1:0] sat_stable(input logic [SW-1:0] v);
    return (v == SW'(DEBOUNCE)) ? v : v + SW'(1);
  endfunction

  logic [COLS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]   dwell;
  logic            dwell_wrap;
  logic            sample;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] rows_q;
  logic            frame_end;

  logic [1:0]      hit_cnt_q;
  logic [CW-1:0]   first_q;
  logic [1:0]      row_hits;
  logic [CLW-1:0]  row_col;
  logic [1:0]      tot_hits;
  logic [CW-1:0]   frame_code;
  res_kind_e       res_kind;

  res_kind_e       prev_kind_q;
  logic [CW-1:0]   prev_code_q;
  logic [SW-1:0]   stable_q, stable_d;
  logic            same;
  logic            commit;

  state_e          state_q;
  logic [CW-1:0]   code_q;
  logic            valid_q;

  // Column synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= cols;
      sync2_q <= sync1_q;
    end
  end

  param_counter #(.UPPER_BOUND(SETTLE)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .count_o (dwell),
    .wrap_o  (dwell_wrap)
  );

  // Row strobe sequencing
  assign sample    = (dwell == DW'(SETTLE - 1));
  assign frame_end = sample && (row_q == RW'(ROWS - 1));

  always_comb begin
    row_d = row_q;
    if (dwell_wrap) begin
      row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      rows_q <= '1;
    end else begin
      row_q  <= row_d;
      rows_q <= ~(ROWS'(1) << row_d);
    end
  end

  assign rows = rows_q;

  // Frame accumulation: scanning columns high-to-low leaves the lowest hit
  always_comb begin
    row_hits = '0;
    row_col  = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!sync2_q[c]) begin
        row_col = CLW'(c);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
  end

  assign tot_hits   = sat_hits({1'b0, hit_cnt_q} + {1'b0, row_hits});
  assign frame_code = (hit_cnt_q != 2'd0) ? first_q
                                          : CW'(row_q) * CW'(COLS) + CW'(row_col);

  always_comb begin
    res_kind = RES_MULTI;
    if (tot_hits == 2'd0)      res_kind = RES_NONE;
    else if (tot_hits == 2'd1) res_kind = RES_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q <= '0;
      first_q   <= '0;
    end else if (sample) begin
      if (frame_end) begin
        hit_cnt_q <= '0;
        first_q   <= '0;
      end else begin
        hit_cnt_q <= tot_hits;
        first_q   <= frame_code;
      end
    end
  end

  // Frame debounce
  assign same = (res_kind == prev_kind_q) &&
                ((res_kind != RES_ONE) || (frame_code == prev_code_q));
  assign stable_d = same ? sat_stable(stable_q) : SW'(1);
  assign commit   = frame_end &&
                    (same ? (stable_q == SW'(DEBOUNCE - 1)) : (DEBOUNCE == 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_kind_q <= RES_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
    end else if (frame_end) begin
      prev_kind_q <= res_kind;
      prev_code_q <= frame_code;
      stable_q    <= stable_d;
    end
  end

  // Committed-state FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (commit) begin
        unique case (state_q)
          ST_IDLE: begin
            if (res_kind == RES_ONE) begin
              state_q <= ST_PRESSED;
              code_q  <= frame_code;
              valid_q <= 1'b1;
            end else if (res_kind == RES_MULTI) begin
              state_q <= ST_ERROR;
            end
          end
          ST_PRESSED: begin
            if (res_kind == RES_ONE) begin
              if (frame_code != code_q) begin
                code_q  <= frame_code;
                valid_q <= 1'b1;
              end
            end else if (res_kind == RES_MULTI) begin
              state_q <= ST_ERROR;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_ERROR: begin
            if (res_kind == RES_NONE) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pressed = (state_q == ST_PRESSED);
  assign error   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_matrix_scanner.sv
// Bench for matrix_scanner: a key-set driven matrix model feeds the DUT and a
// frame-level reference predicts commits, code and status flags.
module tb_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SETTLE   = 4;
  localparam int DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  code;
  logic        valid, pressed, error;
  logic [15:0] keys = '0;
  logic [3:0]  prev_rows = 4'hF;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int vexp   = 0;

  // reference state: kinds 0=none 1=one 2=multi, states 0=idle 1=pressed 2=error
  int m_kind, m_key, m_cnt, m_state, m_code;
  bit m_valid;

  always #5 clk = ~clk;

  matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst(rst), .cols(cols), .rows(rows),
    .code(code), .valid(valid), .pressed(pressed), .error(error)
  );

  // Physical keypad: a held key pulls its column low while its row is strobed
  always_comb begin
    cols = '1;
    for (int r = 0; r < ROWS; r++)
      if (!rows[r])
        for (int c = 0; c < COLS; c++)
          if (keys[r*COLS + c]) cols[c] = 1'b0;
  end

  always @(posedge clk) prev_rows <= rows;
  always @(negedge clk) if (valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_key = 0; m_cnt = 0; m_state = 0; m_code = 0; m_valid = 0;
  endtask

  task automatic model_frame(input logic [15:0] m);
    int n, k, kind;
    bit same, commit;
    n = $countones(m);
    k = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) k = i;
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    same = (kind == m_kind) && (kind != 1 || k == m_key);
    commit = 0;
    if (same) begin
      if (m_cnt < DEBOUNCE) begin
        m_cnt++;
        commit = (m_cnt == DEBOUNCE);
      end
    end else begin
      m_cnt = 1;
      commit = (DEBOUNCE == 1);
    end
    m_kind = kind;
    m_key  = k;
    m_valid = 0;
    if (commit) begin
      case (m_state)
        0: if (kind == 1) begin m_state = 1; m_code = k; m_valid = 1; end
           else if (kind == 2) m_state = 2;
        1: if (kind == 1) begin
             if (k != m_code) begin m_code = k; m_valid = 1; end
           end else if (kind == 2) m_state = 2;
           else m_state = 0;
        default: if (kind == 0) m_state = 0;
      endcase
    end
    if (m_valid) vexp++;
  endtask

  task automatic next_frame_start();
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = (rows == 4'b1110) && (prev_rows != 4'b1110);
    end
    check("frame_sync", found, 1);
  endtask

  task automatic end_frame(input logic [15:0] m);
    model_frame(m);
    check("valid", valid, m_valid);
    check("pressed", pressed, (m_state == 1));
    check("error", error, (m_state == 2));
    check("code", code, m_code);
    @(negedge clk);
    check("valid_width", valid, 0);
  endtask

  task automatic run_frame(input logic [15:0] m);
    keys = m;
    next_frame_start();
    end_frame(m);
  endtask

  task automatic run_n(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  localparam logic [15:0] K0  = 16'h0001;
  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000;

  initial begin
    int v0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_rows", rows, 4'b1111);
    check("rst_code", code, 0);
    check("rst_valid", valid, 0);
    check("rst_pressed", pressed, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    @(negedge clk);
    check("row0_after_release", rows, 4'b1110);

    // partial first frame, then a full frame checked for row-3 timing
    next_frame_start();
    end_frame('0);
    for (int cyc = 2; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc >= 12) check("row3_low", rows, 4'b0111);
    end
    next_frame_start();
    end_frame('0);

    // partially debounced key 9 then reset at cycle 5 of the next frame
    run_frame(K9);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rows", rows, 4'b1111);
    check("midrst_valid", valid, 0);
    check("midrst_pressed", pressed, 0);
    check("midrst_code", code, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    keys = '0;
    model_reset();
    @(negedge clk);
    check("midrst_row0", rows, 4'b1110);
    check("midrst_pulses", vcount, vexp);
    next_frame_start();
    end_frame('0);

    // single key
    v0 = vcount;
    run_n(K9, 5);
    check("single_pulses", vcount - v0, 1);
    check("single_code", code, 9);
    check("single_pressed", pressed, 1);

    // release, bounce, then steady
    run_n('0, 3);
    v0 = vcount;
    for (int i = 0; i < 4; i++) run_frame((i % 2 == 0) ? K9 : 16'h0000);
    check("bounce_pulses", vcount - v0, 0);
    run_n(K9, 3);
    check("bounce_settle_code", code, 9);
    check("bounce_settle_pulses", vcount - v0, 1);

    // release and re-press a different key
    run_n('0, 3);
    check("release_pressed", pressed, 0);
    check("release_code", code, 9);
    run_n(K0, 3);
    check("repress_code", code, 0);

    // multi-key
    v0 = vcount;
    run_n(K0 | K15, 3);
    check("multi_error", error, 1);
    run_n(K15, 3);
    check("multi_hold_error", error, 1);
    check("multi_pulses", vcount - v0, 0);
    run_n('0, 2);
    check("multi_clear", error, 0);

    // key roll
    run_n(K5, 3);
    run_n(K6, 3);
    check("roll_code", code, 6);
    check("roll_pressed", pressed, 1);

    // randomized key sets held for random frame counts
    for (int i = 0; i < 30; i++) begin
      logic [15:0] m;
      int sel, hold;
      sel  = $urandom_range(0, 4);
      hold = $urandom_range(1, 3);
      case (sel)
        0:       m = '0;
        1, 2, 3: m = 16'(1) << $urandom_range(0, 15);
        default: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      run_n(m, hold);
    end

    check("total_pulses", vcount, vexp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
